// File: rtl/lock_disp_pkg.sv
// Shared types and constants for the lock display scanner: state encoding,
// 7-segment glyphs ({g,f,e,d,c,b,a}, active-high) and the anode-off pattern.
package lock_disp_pkg;

  typedef enum logic [1:0] {
    ST_SHOW  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_ALARM = 2'd2
  } disp_state_e;

  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_O     = 7'b0111111;
  localparam logic [6:0] GLYPH_P     = 7'b1110011;
  localparam logic [6:0] GLYPH_N     = 7'b1010100;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  localparam logic [7:0] AN_OFF = 8'hFF;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD to 7-segment glyph converter; non-decimal nibbles
// (0xA-0xF) render as E so a corrupted code is visibly wrong.
module seg7_encode
  import lock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_E;
    case (bcd)
      4'd0: seg = GLYPH_0;
      4'd1: seg = GLYPH_1;
      4'd2: seg = GLYPH_2;
      4'd3: seg = GLYPH_3;
      4'd4: seg = GLYPH_4;
      4'd5: seg = GLYPH_5;
      4'd6: seg = GLYPH_6;
      4'd7: seg = GLYPH_7;
      4'd8: seg = GLYPH_8;
      4'd9: seg = GLYPH_9;
      default: seg = GLYPH_E;
    endcase
  end

endmodule

// File: rtl/lock_display_scanner.sv
// Time-multiplexed 8-digit display driver for the keypad lock (SHOW/OPEN/ALARM).
// Define LOCK_DISP_MASK_EN to show entered digits as dashes instead of values.
module lock_display_scanner
  import lock_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  input  logic [3:0]  entered_count,
  input  logic        unlocked,
  input  logic        alarm,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    slot_q, slot_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [FW-1:0] frame_inc;
  logic          blink_q, blink_d;
  disp_state_e   state_q, state_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic          fs_q, fs_d;

  logic [4:0]    nibble_msb;
  logic [3:0]    nibble;
  logic [3:0]    count_eff;
  logic          slot_entered;
  logic [6:0]    digit_glyph;
  logic [6:0]    show_glyph;
  logic          phase;

  assign nibble_msb   = 5'd31 - {slot_q, 2'b00};
  assign nibble       = digits[nibble_msb -: 4];
  assign count_eff    = (entered_count > 4'd8) ? 4'd8 : entered_count;
  assign slot_entered = ({1'b0, slot_q} < count_eff);
  assign frame_inc    = frame_q + FW'(1);

  seg7_encode u_encode (
    .bcd (nibble),
    .seg (digit_glyph)
  );

`ifdef LOCK_DISP_MASK_EN
  assign show_glyph = slot_entered ? GLYPH_DASH : GLYPH_BLANK;
`else
  assign show_glyph = slot_entered ? digit_glyph : GLYPH_BLANK;
`endif

  // Inputs are only looked at when presc_q is 0 (slot boundary); the glyph is
  // captured into seg_q there and held, which is what freezes a slot.
  always_comb begin
    presc_d = presc_q;
    slot_d  = slot_q;
    frame_d = frame_q;
    blink_d = blink_q;
    state_d = state_q;
    seg_d   = seg_q;
    an_d    = an_q;
    fs_d    = 1'b0;
    phase   = blink_q;

    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      slot_d  = slot_q + 3'd1;
      if (slot_q == 3'd7) begin
        if (frame_inc == FRAME_LAST) begin
          frame_d = '0;
          blink_d = ~blink_q;
        end else begin
          frame_d = frame_inc;
        end
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (presc_q == '0) begin
      if (alarm)         state_d = ST_ALARM;
      else if (unlocked) state_d = ST_OPEN;
      else               state_d = ST_SHOW;

      if (alarm && (state_q != ST_ALARM)) begin
        blink_d = 1'b1;
        phase   = 1'b1;
      end

      an_d = AN_OFF;
      fs_d = (slot_q == 3'd0);
      case (state_d)
        ST_ALARM: seg_d = phase ? GLYPH_DASH : GLYPH_BLANK;
        ST_OPEN: begin
          case (slot_q)
            3'd0:    seg_d = GLYPH_O;
            3'd1:    seg_d = GLYPH_P;
            3'd2:    seg_d = GLYPH_E;
            3'd3:    seg_d = GLYPH_N;
            default: seg_d = GLYPH_BLANK;
          endcase
        end
        default: seg_d = show_glyph;
      endcase
    end else begin
      an_d = ~(8'b0000_0001 << slot_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      slot_q  <= 3'd0;
      frame_q <= '0;
      blink_q <= 1'b1;
      state_q <= ST_SHOW;
      seg_q   <= GLYPH_BLANK;
      an_q    <= AN_OFF;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fs_q    <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_lock_display_scanner.sv
// Scoreboard bench for lock_display_scanner: the stimulus process pushes the
// expected glyph/anode/frame_start of every slot, a monitor pops and compares.
module tb_lock_display_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] digits;
  logic [3:0]  entered_count;
  logic        unlocked;
  logic        alarm;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        frame_start;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  int   m_slot;
  int   m_frame;
  logic m_blink;
  int   m_state;

  lock_display_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .digits        (digits),
    .entered_count (entered_count),
    .unlocked      (unlocked),
    .alarm         (alarm),
    .seg           (seg),
    .an            (an),
    .frame_start   (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] c,
                               input logic u, input logic a);
    digits        = d;
    entered_count = c;
    unlocked      = u;
    alarm         = a;
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1111001;
    endcase
  endfunction

  task automatic modelReset();
    m_slot  = 0;
    m_frame = 0;
    m_blink = 1'b1;
    m_state = 0;
  endtask

  task automatic advanceModel();
    if (m_slot == 7) begin
      m_frame++;
      if (m_frame == BLINK_FRAMES) begin
        m_frame = 0;
        m_blink = ~m_blink;
      end
    end
    m_slot = (m_slot + 1) % 8;
  endtask

  // Expected response of the slot whose boundary is the next rising edge.
  task automatic pushSlot();
    exp_t       e;
    int         nxt;
    int         cnt;
    logic [7:0] one;
    logic [3:0] nib;
    one = 8'b1;
    nxt = alarm ? 2 : (unlocked ? 1 : 0);
    if (nxt == 2 && m_state != 2) m_blink = 1'b1;
    m_state = nxt;
    e.an  = ~(one << m_slot);
    e.fs  = (m_slot == 0);
    e.seg = 7'b0000000;
    if (nxt == 2) begin
      e.seg = m_blink ? 7'b1000000 : 7'b0000000;
    end else if (nxt == 1) begin
      case (m_slot)
        0: e.seg = 7'b0111111;
        1: e.seg = 7'b1110011;
        2: e.seg = 7'b1111001;
        3: e.seg = 7'b1010100;
        default: e.seg = 7'b0000000;
      endcase
    end else begin
      cnt = (entered_count > 4'd8) ? 8 : int'(entered_count);
      nib = digits[31 - 4*m_slot -: 4];
      if (m_slot < cnt) begin
`ifdef LOCK_DISP_MASK_EN
        e.seg = 7'b1000000;
`else
        e.seg = glyph_of(nib);
`endif
      end
    end
    exp_q.push_back(e);
  endtask

  // Entered and left just after a slot-boundary edge (#1 past it).
  task automatic runSlots(input int n);
    repeat (n) begin
      repeat (SCAN_DIV - 1) @(posedge clk);
      advanceModel();
      pushSlot();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic releaseReset();
    #2 rst_n = 1'b1;
    modelReset();
    pushSlot();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a slot is a one-cycle guard (an=FF) followed by SCAN_DIV-1 active cycles.
  initial begin
    logic       guard_seen;
    logic       in_slot;
    int         active_cnt;
    logic [6:0] g_seg;
    logic       g_fs;
    exp_t       cur;
    guard_seen = 1'b0;
    in_slot    = 1'b0;
    active_cnt = 0;
    g_seg      = '0;
    g_fs       = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        guard_seen = 1'b0;
        in_slot    = 1'b0;
      end else if (an == 8'hFF) begin
        if (in_slot) checkOutput("slot_len", active_cnt, SCAN_DIV - 1);
        if (guard_seen) checkOutput("guard_len", 2, 1);
        in_slot    = 1'b0;
        guard_seen = 1'b1;
        g_seg      = seg;
        g_fs       = frame_start;
      end else if (guard_seen) begin
        guard_seen = 1'b0;
        in_slot    = 1'b1;
        active_cnt = 1;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_slot", {24'h0, an}, 32'hFF);
        end else begin
          cur = exp_q.pop_front();
          checkOutput("slot_an", an, cur.an);
          checkOutput("guard_seg", g_seg, cur.seg);
          checkOutput("slot_seg", seg, cur.seg);
          checkOutput("frame_start", g_fs, cur.fs);
        end
      end else if (in_slot) begin
        active_cnt++;
        checkOutput("an_hold", an, cur.an);
        checkOutput("seg_hold", seg, cur.seg);
        checkOutput("fs_low", frame_start, 1'b0);
      end else begin
        checkOutput("missing_guard", {24'h0, an}, 32'hFF);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(32'h21935488, 4'd8, 1'b0, 1'b0);
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_an", an, 8'hFF);
    checkOutput("reset_seg", seg, 7'h00);
    checkOutput("reset_fs", frame_start, 1'b0);
    releaseReset();

    runSlots(16);
    applyStimulus(32'h21935488, 4'd3, 1'b0, 1'b0);
    runSlots(9);
    applyStimulus(32'h21935488, 4'd12, 1'b0, 1'b0);
    runSlots(8);
    applyStimulus(32'hC0000000, 4'd1, 1'b0, 1'b0);
    runSlots(8);
    applyStimulus(32'hC0000000, 4'd8, 1'b1, 1'b0);
    runSlots(9);
    applyStimulus(32'hC0000000, 4'd8, 1'b1, 1'b1);
    runSlots(44);
    applyStimulus(32'h21935488, 4'd8, 1'b0, 1'b0);
    runSlots(1);
    for (int i = 0; i < 8 && m_slot != 5; i++) runSlots(1);

    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_an", an, 8'hFF);
    checkOutput("midreset_seg", seg, 7'h00);
    checkOutput("midreset_fs", frame_start, 1'b0);
    repeat (2) @(negedge clk);
    releaseReset();
    runSlots(10);

    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
